// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode encodings and per-stage payload for shifter_pipe (cout field under SHIFTER_STATUS_EN)
package shifter_pkg;

   localparam logic [1:0] MODE_ROT = 2'b00;
   localparam logic [1:0] MODE_LSH = 2'b01;
   localparam logic [1:0] MODE_ASH = 2'b10;

   // The payload is sized for the widest supported word; a shifter instance
   // uses only the low WIDTH data bits and the low AMT_W amount bits.
   localparam int MAX_WIDTH = 64;
   localparam int MAX_AMT_W = 6;

   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] data;
      logic [MAX_AMT_W-1:0] amt;
      logic                 lr;
      logic [1:0]           mode;
      logic                 fill;
`ifdef SHIFTER_STATUS_EN
      logic                 cout;
`endif
   } stage_t;

endpackage

// File: rtl/bit_reverse_w.sv
// rtl/bit_reverse_w.sv - combinational WIDTH-bit reversal, used at capture and at output
module bit_reverse_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] rev
);

   // Mirror the word: bit i takes bit WIDTH-1-i.
   always_comb begin
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = data[WIDTH-1-i];
      end
   end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined rotate/logical/arithmetic shifter with valid/ready; SHIFTER_STATUS_EN adds out_cout/out_zero
module shifter_pipe #(
   parameter int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_lr,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SHIFTER_STATUS_EN
   ,
   output logic             out_cout,
   output logic             out_zero
`endif
);

   import shifter_pkg::*;

   // pipe[0] is the capture stage; pipe[k] has applied amount bits 0..k-1.
   stage_t           pipe [AMT_W+1];
   stage_t           cap;
   logic             stall;
   logic [WIDTH-1:0] rev_in;
   logic [WIDTH-1:0] last_w;
   logic [WIDTH-1:0] rev_out;
   logic             unused_last;

   // One stage of the right-shift network: shift by 2^b when amount bit b is set.
   // Vacated high bits take the wrapped low bits (rotate) or the fill bit.
   function automatic stage_t stage_step(input stage_t cur, input int b);
      stage_t           nxt;
      logic [WIDTH-1:0] w;
      int               sh;
      nxt = cur;
      w   = cur.data[WIDTH-1:0];
      sh  = 1 << b;
      if (cur.amt[b]) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i + sh < WIDTH) begin
               nxt.data[i] = w[i+sh];
            end else if (cur.mode == MODE_ROT) begin
               nxt.data[i] = w[i+sh-WIDTH];
            end else begin
               nxt.data[i] = cur.fill;
            end
         end
`ifdef SHIFTER_STATUS_EN
         // The highest set amount bit is applied last, so its outgoing bit wins.
         nxt.cout = w[sh-1];
`endif
      end
      return nxt;
   endfunction

   assign stall    = pipe[AMT_W].valid && !out_ready;
   assign in_ready = !stall;

   // Left operations become right operations on the reversed word.
   bit_reverse_w #(.WIDTH(WIDTH)) u_rev_in (
      .data (in_data),
      .rev  (rev_in)
   );

   // Build the capture payload; reserved mode 11 behaves as a logical shift.
   always_comb begin
      cap                   = '0;
      cap.valid             = in_valid;
      cap.data[WIDTH-1:0]   = in_lr ? in_data : rev_in;
      cap.amt[AMT_W-1:0]    = in_amt;
      cap.lr                = in_lr;
      cap.mode              = (in_mode == 2'b11) ? MODE_LSH : in_mode;
      cap.fill              = in_lr && (in_mode == MODE_ASH) && in_data[WIDTH-1];
   end

   // Advance the whole pipeline together; a stall freezes every stage including valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= AMT_W; k++) begin
            pipe[k] <= '0;
         end
      end else if (!stall) begin
         pipe[0] <= cap;
         for (int k = 1; k <= AMT_W; k++) begin
            pipe[k] <= stage_step(pipe[k-1], k - 1);
         end
      end
   end

   assign last_w = pipe[AMT_W].data[WIDTH-1:0];

   bit_reverse_w #(.WIDTH(WIDTH)) u_rev_out (
      .data (last_w),
      .rev  (rev_out)
   );

   assign out_valid = pipe[AMT_W].valid;
   assign out_data  = pipe[AMT_W].lr ? last_w : rev_out;

   // The final stage's control fields and spare data bits have no consumer.
   assign unused_last = ^pipe[AMT_W];

`ifdef SHIFTER_STATUS_EN
   assign out_cout = pipe[AMT_W].cout;
   assign out_zero = pipe[AMT_W].valid && (out_data == '0);
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - self-checking bench for shifter_pipe (vectors, scoreboard, stall and reset sequences)
module tb_shifter_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_lr;
   logic [1:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef SHIFTER_STATUS_EN
   logic       out_cout;
   logic       out_zero;
`endif

   shifter_pipe #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_lr     (in_lr),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SHIFTER_STATUS_EN
      ,
      .out_cout  (out_cout),
      .out_zero  (out_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic       lr;
      logic [1:0] mode;
      logic [7:0] exp_data;
      logic       exp_cout;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       cout;
      logic       zero;
   } exp_t;

   vec_t       vecs [12];
   exp_t       exp_q [$];
   exp_t       e_pop;
   int         checks;
   int         passes;
   int         pops;
   logic       prev_stall;
   logic [7:0] prev_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic exp_t model(input logic [7:0] d, input logic [2:0] n,
                                  input logic lr, input logic [1:0] mode);
      exp_t              r;
      logic signed [7:0] sd;
      sd = d;
      if (mode == 2'b00)
         r.data = lr ? ((d >> n) | (d << (8 - n))) : ((d << n) | (d >> (8 - n)));
      else if (mode == 2'b10 && lr)
         r.data = sd >>> n;
      else
         r.data = lr ? (d >> n) : (d << n);
      if (n == 0) r.cout = 1'b0;
      else        r.cout = lr ? d[n-1] : d[8-n];
      r.zero = (r.data == 8'h00);
      return r;
   endfunction

   // Scoreboard and protocol monitor, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_out", 1, 0);
            end else begin
               e_pop = exp_q.pop_front();
               pops++;
               chk("sb_data", out_data, e_pop.data);
`ifdef SHIFTER_STATUS_EN
               chk("sb_cout", out_cout, e_pop.cout);
               chk("sb_zero", out_zero, e_pop.zero);
`endif
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_data, in_amt, in_lr, in_mode));
         chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (prev_stall) chk("stall_hold", out_data, prev_data);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic apply_vec(input vec_t v, input string tag);
      int lat;
      in_data   = v.data;
      in_amt    = v.amt;
      in_lr     = v.lr;
      in_mode   = v.mode;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_data"}, out_data, v.exp_data);
`ifdef SHIFTER_STATUS_EN
      chk({tag, "_cout"}, out_cout, v.exp_cout);
      chk({tag, "_zero"}, out_zero, (v.exp_data == 8'h00));
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      int accepted;
      int guard;
      int base;
      logic acc;

      vecs[0]  = '{8'hB1, 3'd3, 1'b1, 2'b00, 8'h36, 1'b0};
      vecs[1]  = '{8'hB1, 3'd3, 1'b0, 2'b00, 8'h8D, 1'b1};
      vecs[2]  = '{8'h81, 3'd7, 1'b0, 2'b01, 8'h80, 1'b0};
      vecs[3]  = '{8'h90, 3'd2, 1'b1, 2'b10, 8'hE4, 1'b0};
      vecs[4]  = '{8'h90, 3'd2, 1'b1, 2'b01, 8'h24, 1'b0};
      vecs[5]  = '{8'hA5, 3'd0, 1'b1, 2'b00, 8'hA5, 1'b0};
      vecs[6]  = '{8'hA5, 3'd0, 1'b0, 2'b10, 8'hA5, 1'b0};
      vecs[7]  = '{8'hF0, 3'd4, 1'b0, 2'b11, 8'h00, 1'b1};
      vecs[8]  = '{8'h81, 3'd1, 1'b1, 2'b10, 8'hC0, 1'b1};
      vecs[9]  = '{8'h81, 3'd7, 1'b0, 2'b00, 8'hC0, 1'b0};
      vecs[10] = '{8'h01, 3'd7, 1'b0, 2'b10, 8'h80, 1'b0};
      vecs[11] = '{8'h7F, 3'd7, 1'b1, 2'b10, 8'h00, 1'b1};

      checks = 0; passes = 0; pops = 0;
      prev_stall = 1'b0; prev_data = 8'h00;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0;
      in_lr = 1'b0; in_mode = 2'b00; out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_in_ready", in_ready, 1);
`ifdef SHIFTER_STATUS_EN
      chk("reset_out_cout", out_cout, 0);
      chk("reset_out_zero", out_zero, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back random words with out_ready toggling every cycle.
      base     = pops;
      accepted = 0;
      guard    = 0;
      in_data  = 8'($urandom); in_amt = 3'($urandom_range(0, 7));
      in_lr    = 1'($urandom); in_mode = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      out_ready = 1'b0;
      while (accepted < 16 && guard < 400) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         guard++;
         out_ready = ~out_ready;
         if (acc) begin
            accepted++;
            if (accepted < 16) begin
               in_data = 8'($urandom); in_amt = 3'($urandom_range(0, 7));
               in_lr   = 1'($urandom); in_mode = 2'($urandom_range(0, 3));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("burst_accepted", accepted, 16);
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("burst_drained", exp_q.size(), 0);
      chk("burst_count", pops - base, 16);

      // Three words in flight, then a one-cycle reset flushes them all.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h11 + 8'(i); in_amt = 3'd1; in_lr = 1'b1; in_mode = 2'b00;
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_flush_valid", out_valid, 0);
      chk("rst_flush_data", out_data, 0);
      chk("rst_flush_in_ready", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         chk("rst_flush_quiet", out_valid, 0);
         @(posedge clk); #1;
      end
      apply_vec(vecs[1], "post_rst");
      repeat (2) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
